// File: rtl/borrow_lookahead_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : borrow_lookahead_sub_seq
// Purpose  : Multi-cycle subtractor, diff = a - b - bin. One 4-bit slice is
//            processed per clock, LSB slice first. Each slice uses 4-bit
//            borrow-lookahead logic. The slice borrow-out is registered
//            between cycles. A start/done handshake controls each operation.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request, sampled in IDLE or DONE only
//            a, b   - minuend / subtrahend, captured when start is accepted
//            bin    - borrow-in, captured when start is accepted
//            add_sel- (BORROW_LOOKAHEAD_ADD_EN only) 1 selects a + b + bin
//            busy   - high while slices are being processed
//            done   - one-cycle pulse, result valid
//            diff   - result, held until the next accepted start
//            bout   - borrow (or carry in add mode) out of the MSB
//            ovf    - two's-complement overflow
// Options  : define BORROW_LOOKAHEAD_ADD_EN to add the add_sel port and
//            carry-lookahead addition on the same slice datapath.
// Revision : 1.0 - initial release
// ============================================================================
module borrow_lookahead_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef BORROW_LOOKAHEAD_ADD_EN
  input  logic             add_sel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [CW+1:0]    w_base;
  logic [3:0]       w_a4;
  logic [3:0]       w_b4;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_d;
  logic             w_sign_rule;
  logic             w_ovf;

`ifdef BORROW_LOOKAHEAD_ADD_EN
  logic             r_add;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_cnt == C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back accept goes straight to RUN without an IDLE cycle.
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slice datapath
  // --------------------------------------------------------------------------
  assign w_base = {r_cnt, 2'b00};
  assign w_a4   = r_a[w_base +: 4];
  assign w_b4   = r_b[w_base +: 4];

`ifdef BORROW_LOOKAHEAD_ADD_EN
  // Carry generate/propagate for addition, borrow generate/propagate for
  // subtraction; the lookahead network below is shared by both.
  assign w_g = r_add ? (w_a4 & w_b4)    : (~w_a4 & w_b4);
  assign w_p = r_add ? (w_a4 ^ w_b4)    : ~(w_a4 ^ w_b4);
`else
  assign w_g = ~w_a4 & w_b4;
  assign w_p = ~(w_a4 ^ w_b4);
`endif

  // Fully expanded lookahead: every slice-internal borrow depends only on
  // g, p and the registered slice borrow-in, never on a rippled neighbour.
  assign w_c[0] = r_brw;
  assign w_c[1] = w_g[0] | (w_p[0] & r_brw);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_brw);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_brw);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_brw);

  assign w_d = w_a4 ^ w_b4 ^ w_c[3:0];

  // Overflow is only evaluated on the last slice, so w_d[3] is the final
  // result MSB at that point.
`ifdef BORROW_LOOKAHEAD_ADD_EN
  assign w_sign_rule = r_add ? (r_a[WIDTH-1] == r_b[WIDTH-1])
                             : (r_a[WIDTH-1] != r_b[WIDTH-1]);
`else
  assign w_sign_rule = (r_a[WIDTH-1] != r_b[WIDTH-1]);
`endif
  assign w_ovf = w_sign_rule & (w_d[3] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef BORROW_LOOKAHEAD_ADD_EN
      r_add  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_brw <= bin;
      r_cnt <= '0;
`ifdef BORROW_LOOKAHEAD_ADD_EN
      r_add <= add_sel;
`endif
    end else if (r_state == ST_RUN) begin
      r_diff[w_base +: 4] <= w_d;
      r_brw               <= w_c[4];
      if (w_last) begin
        r_bout <= w_c[4];
        r_ovf  <= w_ovf;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire
